// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Brief    : Drains a synchronous byte FIFO (rd_en / empty / registered rdata)
//            and packs LANES consecutive entries into one valid/ready word.
//            Partial words leave on flush_i. When FIFO_PACK_TIMEOUT_EN is
//            defined, an idle timer also flushes after TIMEOUT idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  input  logic [WIDTH-1:0]       fifo_rdata_i,
  input  logic                   flush_i,
  output logic [WIDTH*LANES-1:0] m_data_o,
  output logic [LANES-1:0]       m_keep_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i
);

  localparam logic [CNT_W:0]   c_lanes_ext = (CNT_W+1)'(LANES);
  localparam logic [CNT_W-1:0] c_lanes     = CNT_W'(LANES);

  // Assembly side state
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [WIDTH*LANES-1:0] asm_q, asm_d;
  logic                   flush_pend_q, flush_pend_d;

  // Output register state
  logic [WIDTH*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;

  logic             w_out_free;
  logic             w_occupied;
  logic             w_room;
  logic             w_can_pop;
  logic             w_timeout;
  logic             w_flush_req;
  logic             w_flush_eff;
  logic             w_full;
  logic             w_xfer;
  logic [LANES-1:0] w_keep_mask;

  assign w_out_free = !valid_q || m_ready_i;
  // A byte is either already in a lane or still in flight from the FIFO.
  assign w_occupied = (cnt_q != '0) || pend_q;
  // In-flight bytes reserve a lane, so cnt + pend never exceeds LANES.
  assign w_room     = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q}) < c_lanes_ext;
  // Pop permission before a fresh flush request is taken into account; the
  // idle timer looks at this so that the timeout path has no loop through it.
  assign w_can_pop  = !rst_i && !fifo_empty_i && w_room && !flush_pend_q;
  assign w_full     = (cnt_q == c_lanes);

`ifdef FIFO_PACK_TIMEOUT_EN
  localparam int                c_tmr_w      = $clog2(TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_timeout_m1 = c_tmr_w'(TIMEOUT - 1);

  logic [c_tmr_w-1:0] timer_q, timer_d;
  logic               w_idle;

  assign w_idle    = (cnt_q != '0) && !pend_q && !w_can_pop;
  // Fires on the edge that completes the TIMEOUT-th idle cycle.
  assign w_timeout = w_idle && (timer_q == c_timeout_m1);

  // Idle timer: restarts on capture, transfer or its own expiry.
  always_comb begin
    timer_d = timer_q;
    if (w_xfer || pend_q || w_timeout) begin
      timer_d = '0;
    end else if (w_idle) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Idle timer register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  // No timer in this build; TIMEOUT is kept in the parameter list so both
  // builds share one interface, and this constant-false term consumes it.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // A flush only means something when there is data to emit.
  assign w_flush_req  = (flush_i || w_timeout) && w_occupied;
  assign w_flush_eff  = flush_pend_q || w_flush_req;
  assign fifo_rd_en_o = w_can_pop && !w_flush_req;
  // Partial words wait for the in-flight byte before leaving.
  assign w_xfer       = w_out_free &&
                        (w_full || (w_flush_eff && !pend_q && (cnt_q != '0)));

  // Lane-valid mask for the word currently being assembled.
  always_comb begin
    w_keep_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_keep_mask[i] = (CNT_W'(i) < cnt_q);
    end
  end

  // Next-state: capture into lane cnt, or move the assembly to the output.
  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    pend_d       = fifo_rd_en_o;
    flush_pend_d = flush_pend_q || w_flush_req;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    valid_d      = valid_q;

    if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end

    // Transfer and capture are exclusive: a transfer needs pend_q == 0.
    if (w_xfer) begin
      data_d       = asm_q;
      keep_d       = w_keep_mask;
      last_d       = w_flush_eff;
      valid_d      = 1'b1;
      cnt_d        = '0;
      asm_d        = '0;
      flush_pend_d = 1'b0;
    end else if (pend_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          asm_d[i*WIDTH +: WIDTH] = fifo_rdata_i;
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      asm_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      asm_q        <= asm_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
    end
  end

  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  assign m_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Brief    : Self-checking bench for fifo_word_packer. A queue-like FIFO model
//            feeds the DUT; accepted words are collected and compared with
//            words built directly from the pushed byte stream.
//            Honours FIFO_PACK_TIMEOUT_EN in the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .WIDTH(8), .LANES(4), .CNT_W(3), .TIMEOUT(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_rdata_i (fifo_rdata),
    .flush_i      (flush),
    .m_data_o     (m_data),
    .m_keep_o     (m_keep),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready)
  );

  // ---------------- FIFO model: array + push/pop counters ----------------
  logic [7:0] mem [0:1023];
  int         pop_edge [0:1023];
  int         n_push = 0;
  int         n_pop  = 0;
  int         cyc    = 0;
  logic       rd_en_s = 1'b0;

  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_s) begin
      fifo_rdata      <= mem[n_pop];
      pop_edge[n_pop] <= cyc + 1;
      n_pop           <= n_pop + 1;
    end
  end

  // ---------------- Output monitor (samples just before each rising edge) --
  logic [31:0] got_data [0:255];
  logic [3:0]  got_keep [0:255];
  logic        got_last [0:255];
  int          word_edge [0:255];
  int          n_got = 0;
  int          n_seen = 0;
  int          stab_err = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [36:0] prev_w = '0;

  always @(negedge clk) begin
    #4;
    rd_en_s = fifo_rd_en;
    if (m_valid && (!prev_v || prev_r)) begin
      word_edge[n_seen] = cyc;
      n_seen++;
    end
    if (prev_v && !prev_r && !rst) begin
      if (!m_valid || ({m_data, m_keep, m_last} != prev_w)) stab_err++;
    end
    if (m_valid && m_ready) begin
      got_data[n_got] = m_data;
      got_keep[n_got] = m_keep;
      got_last[n_got] = m_last;
      n_got++;
    end
    prev_v = m_valid;
    prev_r = m_ready;
    prev_w = {m_data, m_keep, m_last};
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=300000", $time);
    $fatal(1);
  end

  int checks = 0;
  int passed = 0;

  task automatic push(input logic [7:0] b);
    mem[n_push] = b;
    n_push++;
  endtask

  task automatic wait_got(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_got < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (n_got >= target);
  endtask

  task automatic wait_popped(output bit ok);
    int k = 0;
    while (n_pop != n_push && k < 40) begin
      @(negedge clk);
      k++;
    end
    ok = (n_pop == n_push);
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, m_last, m_keep, m_data} !== 38'h0) begin
      $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h want all zero",
               m_valid, m_last, m_keep, m_data);
    end else passed++;
    // FIFO non-empty while in reset: no pop may be requested.
    push(8'h11);
    @(negedge clk);
    checks++;
    if (rd_en_s !== 1'b0 || n_pop !== 0) begin
      $display("FAIL reset_no_pop: got rd_en=%b pops=%0d want 0/0", rd_en_s, n_pop);
    end else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    int s0 = n_seen;
    int g0 = n_got;
    push(8'h22); push(8'h33); push(8'h44);
    wait_got(g0 + 1, 30, ok);
    checks++;
    if (!ok) $display("FAIL basic_wait: got %0d words want %0d", n_got - g0, 1);
    else passed++;
    checks++;
    if ({got_data[g0], got_keep[g0], got_last[g0]} !== {32'h44332211, 4'hf, 1'b0}) begin
      $display("FAIL basic_word: got d=%h k=%b l=%b want d=44332211 k=1111 l=0",
               got_data[g0], got_keep[g0], got_last[g0]);
    end else passed++;
    checks++;
    if (word_edge[s0] - pop_edge[0] !== 5) begin
      $display("FAIL basic_latency: got %0d edges want 5", word_edge[s0] - pop_edge[0]);
    end else passed++;
  endtask

  task automatic test_hold();
    bit ok;
    logic [7:0]  b [0:11];
    logic [31:0] exp;
    int s0 = n_seen;
    int g0 = n_got;
    int p0 = n_pop;
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    repeat (12) @(negedge clk);
    checks++;
    if ((n_seen - s0) !== 1 || (n_pop - p0) !== 8 || rd_en_s !== 1'b0) begin
      $display("FAIL hold_state: got words=%0d pops=%0d rd_en=%b want 1/8/0",
               n_seen - s0, n_pop - p0, rd_en_s);
    end else passed++;
    exp = {b[3], b[2], b[1], b[0]};
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp) begin
      $display("FAIL hold_output: got v=%b d=%h want v=1 d=%h", m_valid, m_data, exp);
    end else passed++;
    m_ready = 1'b1;
    wait_got(g0 + 3, 40, ok);
    checks++;
    if (!ok) $display("FAIL hold_wait: got %0d words want 3", n_got - g0);
    else passed++;
    for (int w = 0; w < 3; w++) begin
      exp = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
      checks++;
      if ({got_data[g0+w], got_keep[g0+w], got_last[g0+w]} !== {exp, 4'hf, 1'b0}) begin
        $display("FAIL hold_word%0d: got d=%h k=%b l=%b want d=%h k=1111 l=0",
                 w, got_data[g0+w], got_keep[g0+w], got_last[g0+w], exp);
      end else passed++;
    end
    checks++;
    if (stab_err !== 0) $display("FAIL hold_stable: got %0d changes want 0", stab_err);
    else passed++;
  endtask

  task automatic test_flush();
    bit ok;
    logic [7:0]  b [0:2];
    logic [31:0] exp;
    logic [3:0]  kexp;
    int          k;
    for (int it = 0; it < 5; it++) begin
      int g0 = n_got;
      if (it == 0) begin
        k = 2; b[0] = 8'hA1; b[1] = 8'hB2; b[2] = 8'h00;
      end else begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < 3; j++) b[j] = 8'($urandom);
      end
      for (int j = 0; j < k; j++) push(b[j]);
      wait_popped(ok);
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_got(g0 + 1, 10, ok);
      exp = 32'h0;
      kexp = 4'h0;
      for (int j = 0; j < k; j++) begin
        exp[j*8 +: 8] = b[j];
        kexp[j] = 1'b1;
      end
      checks++;
      if (!ok || {got_data[g0], got_keep[g0], got_last[g0]} !== {exp, kexp, 1'b1}) begin
        $display("FAIL flush_partial%0d: got d=%h k=%b l=%b want d=%h k=%b l=1",
                 it, got_data[g0], got_keep[g0], got_last[g0], exp, kexp);
      end else passed++;
    end
  endtask

  task automatic test_flush_full();
    bit ok;
    logic [7:0] b [0:7];
    int g0 = n_got;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    repeat (12) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    wait_got(g0 + 2, 20, ok);
    checks++;
    if (!ok || {got_data[g0], got_last[g0]} !== {b[3], b[2], b[1], b[0], 1'b0}) begin
      $display("FAIL flush_full_first: got d=%h l=%b want d=%h l=0",
               got_data[g0], got_last[g0], {b[3], b[2], b[1], b[0]});
    end else passed++;
    checks++;
    if ({got_data[g0+1], got_keep[g0+1], got_last[g0+1]} !==
        {b[7], b[6], b[5], b[4], 4'hf, 1'b1}) begin
      $display("FAIL flush_full_second: got d=%h k=%b l=%b want d=%h k=1111 l=1",
               got_data[g0+1], got_keep[g0+1], got_last[g0+1], {b[7], b[6], b[5], b[4]});
    end else passed++;
  endtask

  task automatic test_flush_empty();
    int s0 = n_seen;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if ((n_seen - s0) !== 0 || m_valid !== 1'b0) begin
      $display("FAIL flush_empty: got words=%0d v=%b want 0/0", n_seen - s0, m_valid);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0]  b [0:3];
    logic [31:0] exp;
    int s0 = n_seen;
    int g0 = n_got;
    push(8'hC1); push(8'hC2);
    wait_popped(ok);
    repeat (2) @(negedge clk);
    checks++;
    if ((n_seen - s0) !== 0) $display("FAIL midrst_premature: got %0d words want 0", n_seen - s0);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, m_keep, m_data} !== 38'h0) begin
      $display("FAIL midrst_outputs: got v=%b l=%b k=%h d=%h want all zero",
               m_valid, m_last, m_keep, m_data);
    end else passed++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    wait_got(g0 + 1, 30, ok);
    exp = {b[3], b[2], b[1], b[0]};
    checks++;
    if (!ok || {got_data[g0], got_keep[g0], got_last[g0]} !== {exp, 4'hf, 1'b0}) begin
      $display("FAIL midrst_clean: got d=%h k=%b l=%b want d=%h k=1111 l=0",
               got_data[g0], got_keep[g0], got_last[g0], exp);
    end else passed++;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0]  b [0:31];
    logic [31:0] exp;
    int pushed = 0;
    int gap = 0;
    int g0 = n_got;
    while (pushed < 32) begin
      @(negedge clk);
      m_ready = ($urandom_range(0, 3) != 0);
      if (gap >= 3 || $urandom_range(0, 1) == 1) begin
        b[pushed] = 8'($urandom);
        push(b[pushed]);
        pushed++;
        gap = 0;
      end else gap++;
    end
    @(negedge clk);
    m_ready = 1'b1;
    wait_got(g0 + 8, 100, ok);
    checks++;
    if (!ok) $display("FAIL random_wait: got %0d words want 8", n_got - g0);
    else passed++;
    for (int w = 0; w < 8; w++) begin
      exp = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
      checks++;
      if ({got_data[g0+w], got_keep[g0+w], got_last[g0+w]} !== {exp, 4'hf, 1'b0}) begin
        $display("FAIL random_word%0d: got d=%h k=%b l=%b want d=%h k=1111 l=0",
                 w, got_data[g0+w], got_keep[g0+w], got_last[g0+w], exp);
      end else passed++;
    end
    checks++;
    if (stab_err !== 0) $display("FAIL random_stable: got %0d changes want 0", stab_err);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int s0 = n_seen;
    int g0 = n_got;
    int idx = n_push;
    push(8'h5C);
`ifdef FIFO_PACK_TIMEOUT_EN
    wait_got(g0 + 1, 40, ok);
    checks++;
    if (!ok || {got_data[g0], got_keep[g0], got_last[g0]} !== {32'h5C, 4'b0001, 1'b1}) begin
      $display("FAIL timeout_word: got d=%h k=%b l=%b want d=0000005c k=0001 l=1",
               got_data[g0], got_keep[g0], got_last[g0]);
    end else passed++;
    checks++;
    if (word_edge[s0] - (pop_edge[idx] + 1) !== 16) begin
      $display("FAIL timeout_delay: got %0d edges want 16",
               word_edge[s0] - (pop_edge[idx] + 1));
    end else passed++;
`else
    repeat (40) @(negedge clk);
    checks++;
    if ((n_seen - s0) !== 0 || n_pop !== idx + 1) begin
      $display("FAIL no_timeout: got words=%0d pops=%0d want 0/%0d", n_seen - s0, n_pop, idx + 1);
    end else passed++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_got(g0 + 1, 10, ok);
    checks++;
    if (!ok || {got_data[g0], got_keep[g0], got_last[g0]} !== {32'h5C, 4'b0001, 1'b1}) begin
      $display("FAIL no_timeout_flush: got d=%h k=%b l=%b want d=0000005c k=0001 l=1",
               got_data[g0], got_keep[g0], got_last[g0]);
    end else passed++;
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    test_reset();
    test_basic();
    test_hold();
    test_flush();
    test_flush_full();
    test_flush_empty();
    test_reset_mid();
    test_random();
    test_timeout();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
